// File: rtl/flag_intr_unit_pkg.sv
// Shared constants for the CPU status block: flag load-source select encoding.
package flag_intr_unit_pkg;

  localparam logic FLG_SRC_ALU  = 1'b0;
  localparam logic FLG_SRC_SHAD = 1'b1;

endpackage

// File: rtl/flag_intr_unit_irq_sync.sv
// Brings the asynchronous irq_in into the clk domain and flags rising edges of
// the synchronised level.
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic irq_in,
  output logic irq_s,
  output logic irq_rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   irq_d_q, irq_d_d;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], irq_in};
    irq_d_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      irq_d_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      irq_d_q <= irq_d_d;
    end
  end

  // irq_d_q trails irq_s by one cycle, so their difference is a one-cycle pulse.
  assign irq_s    = sync_q[SYNC_STAGES-1];
  assign irq_rise = sync_q[SYNC_STAGES-1] & ~irq_d_q;

endmodule

// File: rtl/flag_intr_unit.sv
// Processor status state: C/Z flags, their shadow copies, interrupt enable and
// the pending-interrupt latch fed by the synchronised external request.
module flag_intr_unit
  import flag_intr_unit_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic alu_c,
  input  logic alu_z,
  input  logic flg_c_set,
  input  logic flg_c_clr,
  input  logic flg_c_ld,
  input  logic flg_z_ld,
  input  logic flg_ld_sel,
  input  logic flg_shad_ld,
  input  logic i_set,
  input  logic i_clr,
  input  logic int_ack,
  input  logic irq_in,
  output logic c,
  output logic z,
  output logic shad_c,
  output logic shad_z,
  output logic i_en,
  output logic int_pending,
  output logic interrupt
);

  logic c_q, c_d;
  logic z_q, z_d;
  logic shad_c_q, shad_c_d;
  logic shad_z_q, shad_z_d;
  logic i_en_q, i_en_d;
  logic pend_q, pend_d;
  logic irq_s, irq_rise;
  logic src_c, src_z;

  irq_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_irq_sync (
    .clk     (clk),
    .reset   (reset),
    .irq_in  (irq_in),
    .irq_s   (irq_s),
    .irq_rise(irq_rise)
  );

  // All next-state terms read only the current registers, so a shadow load
  // combined with a shadow-sourced flag load swaps the two sets.
  always_comb begin
    src_c    = (flg_ld_sel == FLG_SRC_SHAD) ? shad_c_q : alu_c;
    src_z    = (flg_ld_sel == FLG_SRC_SHAD) ? shad_z_q : alu_z;
    c_d      = c_q;
    z_d      = z_q;
    shad_c_d = shad_c_q;
    shad_z_d = shad_z_q;
    i_en_d   = i_en_q;
    pend_d   = pend_q;

    if (flg_c_clr)      c_d = 1'b0;
    else if (flg_c_set) c_d = 1'b1;
    else if (flg_c_ld)  c_d = src_c;

    if (flg_z_ld) z_d = src_z;

    if (flg_shad_ld) begin
      shad_c_d = c_q;
      shad_z_d = z_q;
    end

    if (int_ack || i_clr) i_en_d = 1'b0;
    else if (i_set)       i_en_d = 1'b1;

    // A new edge beats a same-cycle acknowledge so that request is not lost.
    if (EDGE_MODE) begin
      if (irq_rise)     pend_d = 1'b1;
      else if (int_ack) pend_d = 1'b0;
    end else begin
      pend_d = irq_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      shad_c_q <= 1'b0;
      shad_z_q <= 1'b0;
      i_en_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      c_q      <= c_d;
      z_q      <= z_d;
      shad_c_q <= shad_c_d;
      shad_z_q <= shad_z_d;
      i_en_q   <= i_en_d;
      pend_q   <= pend_d;
    end
  end

  assign c           = c_q;
  assign z           = z_q;
  assign shad_c      = shad_c_q;
  assign shad_z      = shad_z_q;
  assign i_en        = i_en_q;
  assign int_pending = pend_q;
  assign interrupt   = pend_q & i_en_q;

endmodule

// File: tb/tb_flag_intr_unit.sv
// Bench for flag_intr_unit: an edge-mode and a level-mode instance share one
// stimulus stream and are checked every cycle against a reference model.
module tb_flag_intr_unit;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic reset, alu_c, alu_z, flg_c_set, flg_c_clr, flg_c_ld, flg_z_ld;
  logic flg_ld_sel, flg_shad_ld, i_set, i_clr, int_ack, irq_in;

  logic e_c, e_z, e_sc, e_sz, e_i, e_p, e_int;
  logic l_c, l_z, l_sc, l_sz, l_i, l_p, l_int;

  int n_tests = 0;
  int n_fail  = 0;
  logic [13:0] exp_q[$];

  // Reference model state
  logic m_c, m_z, m_sc, m_sz, m_i, m_pe, m_pl;
  logic hist[$];

  always #5 clk = ~clk;

  flag_intr_unit #(.SYNC_STAGES(SYNC), .EDGE_MODE(1'b1)) u_edge (
    .clk(clk), .reset(reset), .alu_c(alu_c), .alu_z(alu_z),
    .flg_c_set(flg_c_set), .flg_c_clr(flg_c_clr), .flg_c_ld(flg_c_ld),
    .flg_z_ld(flg_z_ld), .flg_ld_sel(flg_ld_sel), .flg_shad_ld(flg_shad_ld),
    .i_set(i_set), .i_clr(i_clr), .int_ack(int_ack), .irq_in(irq_in),
    .c(e_c), .z(e_z), .shad_c(e_sc), .shad_z(e_sz), .i_en(e_i),
    .int_pending(e_p), .interrupt(e_int)
  );

  flag_intr_unit #(.SYNC_STAGES(SYNC), .EDGE_MODE(1'b0)) u_lvl (
    .clk(clk), .reset(reset), .alu_c(alu_c), .alu_z(alu_z),
    .flg_c_set(flg_c_set), .flg_c_clr(flg_c_clr), .flg_c_ld(flg_c_ld),
    .flg_z_ld(flg_z_ld), .flg_ld_sel(flg_ld_sel), .flg_shad_ld(flg_shad_ld),
    .i_set(i_set), .i_clr(i_clr), .int_ack(int_ack), .irq_in(irq_in),
    .c(l_c), .z(l_z), .shad_c(l_sc), .shad_z(l_sz), .i_en(l_i),
    .int_pending(l_p), .interrupt(l_int)
  );

  task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] dut_vec();
    return {e_c, e_z, e_sc, e_sz, e_i, e_p, e_int, l_c, l_z, l_sc, l_sz, l_i, l_p, l_int};
  endfunction

  function automatic logic [13:0] model_vec();
    return {m_c, m_z, m_sc, m_sz, m_i, m_pe, m_pe & m_i,
            m_c, m_z, m_sc, m_sz, m_i, m_pl, m_pl & m_i};
  endfunction

  // hist holds irq_in as sampled at each past edge, newest at the back.
  // The synchronised level seen at an edge is the sample from SYNC edges earlier.
  task automatic model_step();
    logic n_c, n_z, lvl_now, lvl_prev;
    if (reset) begin
      {m_c, m_z, m_sc, m_sz, m_i, m_pe, m_pl} = '0;
      hist = {};
      for (int k = 0; k <= SYNC; k++) hist.push_back(1'b0);
      return;
    end
    lvl_now  = hist[hist.size() - SYNC];
    lvl_prev = hist[hist.size() - SYNC - 1];
    n_c = m_c;
    n_z = m_z;
    if (flg_c_clr)      n_c = 1'b0;
    else if (flg_c_set) n_c = 1'b1;
    else if (flg_c_ld)  n_c = flg_ld_sel ? m_sc : alu_c;
    if (flg_z_ld)       n_z = flg_ld_sel ? m_sz : alu_z;
    if (flg_shad_ld) begin
      m_sc = m_c;
      m_sz = m_z;
    end
    m_c = n_c;
    m_z = n_z;
    if (int_ack || i_clr) m_i = 1'b0;
    else if (i_set)       m_i = 1'b1;
    if (lvl_now && !lvl_prev) m_pe = 1'b1;
    else if (int_ack)         m_pe = 1'b0;
    m_pl = lvl_now;
    hist.push_back(irq_in);
    void'(hist.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    exp_q.push_back(model_vec());
    @(negedge clk);
    check("state", dut_vec(), exp_q.pop_front());
  endtask

  task automatic clear_ctl();
    {reset, alu_c, alu_z, flg_c_set, flg_c_clr, flg_c_ld, flg_z_ld} = '0;
    {flg_ld_sel, flg_shad_ld, i_set, i_clr, int_ack} = '0;
  endtask

  initial begin
    {reset, alu_c, alu_z, flg_c_set, flg_c_clr, flg_c_ld, flg_z_ld} = '1;
    {flg_ld_sel, flg_shad_ld, i_set, i_clr, int_ack, irq_in} = '1;
    tick();
    check("reset_all_zero", dut_vec(), 14'h0);
    clear_ctl();
    irq_in = 1'b0;
    tick();

    // Flag loads, clear-over-load, set
    alu_c = 1'b1; alu_z = 1'b1; flg_c_ld = 1'b1; flg_z_ld = 1'b1;
    tick();
    check("alu_ld_c", 14'(e_c), 14'd1);
    check("alu_ld_z", 14'(e_z), 14'd1);
    clear_ctl(); flg_c_clr = 1'b1; flg_c_ld = 1'b1; alu_c = 1'b1;
    tick();
    check("clr_beats_ld", 14'(e_c), 14'd0);
    clear_ctl(); flg_c_set = 1'b1;
    tick();
    check("set_c", 14'(e_c), 14'd1);

    // Shadow round trip and swap
    clear_ctl(); flg_z_ld = 1'b1; alu_z = 1'b0;
    tick();
    clear_ctl(); flg_shad_ld = 1'b1;
    tick();
    check("shad_cap", 14'({e_sc, e_sz}), 14'b10);
    clear_ctl(); alu_c = 1'b0; alu_z = 1'b1; flg_c_ld = 1'b1; flg_z_ld = 1'b1;
    tick();
    check("alu_ld_cz", 14'({e_c, e_z}), 14'b01);
    clear_ctl(); flg_ld_sel = 1'b1; flg_c_ld = 1'b1; flg_z_ld = 1'b1; flg_shad_ld = 1'b1;
    tick();
    check("swap_flags", 14'({e_c, e_z}), 14'b10);
    check("swap_shadow", 14'({e_sc, e_sz}), 14'b01);
    clear_ctl(); flg_ld_sel = 1'b1; flg_c_ld = 1'b1; flg_z_ld = 1'b1;
    tick();
    check("shad_restore", 14'({e_c, e_z}), 14'b01);

    // Masked interrupt, then enable, then acknowledge
    clear_ctl(); i_clr = 1'b1;
    tick();
    clear_ctl(); irq_in = 1'b1;
    tick();
    irq_in = 1'b0;
    tick();
    check("pend_not_yet", 14'(e_p), 14'd0);
    tick();
    check("pend_masked", 14'({e_p, e_int}), 14'b10);
    i_set = 1'b1;
    tick();
    check("int_after_sei", 14'(e_int), 14'd1);
    clear_ctl(); int_ack = 1'b1;
    tick();
    check("ack_clears", 14'({e_p, e_i, e_int}), 14'b000);

    // Rise colliding with ack, then edges collapsing
    clear_ctl(); irq_in = 1'b1;
    tick();
    irq_in = 1'b0;
    tick();
    int_ack = 1'b1;
    tick();
    check("rise_beats_ack", 14'(e_p), 14'd1);
    clear_ctl();
    for (int k = 0; k < 4; k++) begin
      irq_in = (k % 2 == 0);
      tick();
    end
    tick(); tick();
    check("two_edges_pend", 14'(e_p), 14'd1);
    int_ack = 1'b1;
    tick();
    clear_ctl();
    tick();
    check("single_pending", 14'(e_p), 14'd0);

    // Reset discards a pending interrupt
    irq_in = 1'b1; tick(); irq_in = 1'b0; tick(); tick();
    reset = 1'b1;
    tick();
    check("reset_discard", dut_vec(), 14'h0);
    clear_ctl(); tick();

    // Level mode: pending tracks irq_s; ack leaves it alone
    i_set = 1'b1;
    tick();
    clear_ctl();
    for (int j = 0; j < 9; j++) begin
      irq_in  = (j < 5);
      int_ack = (j == 3);
      tick();
      check("lvl_pend", 14'(l_p), 14'((j >= 2 && j <= 6) ? 1 : 0));
    end
    clear_ctl(); tick(); tick();

    // Randomised traffic
    for (int n = 0; n < 500; n++) begin
      reset       = ($urandom_range(0, 49) == 0);
      alu_c       = 1'($urandom_range(0, 1));
      alu_z       = 1'($urandom_range(0, 1));
      flg_c_set   = ($urandom_range(0, 5) == 0);
      flg_c_clr   = ($urandom_range(0, 5) == 0);
      flg_c_ld    = ($urandom_range(0, 3) == 0);
      flg_z_ld    = ($urandom_range(0, 3) == 0);
      flg_ld_sel  = 1'($urandom_range(0, 1));
      flg_shad_ld = ($urandom_range(0, 4) == 0);
      i_set       = ($urandom_range(0, 5) == 0);
      i_clr       = ($urandom_range(0, 7) == 0);
      int_ack     = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 3) == 0) irq_in = ~irq_in;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flag_intr_unit.md
Name: flag_intr_unit

Overview:
- Holds the processor status state that the control unit reads and drives: C and Z flags, shadow C/Z, interrupt-enable (I), and the pending-interrupt latch.
- Executes the control unit's flg_*, i_set, i_clr and int_ack strobes.
- Returns registered c, z and interrupt to the control unit.
- Synchronises the asynchronous external irq_in into the clk domain.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the irq_in synchroniser (minimum 2).
- EDGE_MODE, 1, 1 = latch synchronised rising edges of irq_in; 0 = pending follows the synchronised level.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- alu_c  in  1  carry result from ALU
- alu_z  in  1  zero result from ALU
- flg_c_set  in  1  set C
- flg_c_clr  in  1  clear C
- flg_c_ld  in  1  load C from selected source
- flg_z_ld  in  1  load Z from selected source
- flg_ld_sel  in  1  load source: 0 = ALU, 1 = shadow
- flg_shad_ld  in  1  copy current C/Z into shadow
- i_set  in  1  set I
- i_clr  in  1  clear I
- int_ack  in  1  control unit is in its interrupt state this cycle
- irq_in  in  1  external interrupt request, asynchronous
- c  out  1  carry flag
- z  out  1  zero flag
- shad_c  out  1  shadow carry
- shad_z  out  1  shadow zero
- i_en  out  1  interrupt enable
- int_pending  out  1  pending latch, unmasked
- interrupt  out  1  int_pending & i_en, to the control unit

Behaviour:
- All state updates on posedge clk. reset has priority over every other input.
- Reset values: c, z, shad_c, shad_z, i_en, int_pending and all synchroniser/edge registers = 0. interrupt = 0.
- C next-state priority:
  - flg_c_clr -> 0
  - else flg_c_set -> 1
  - else flg_c_ld -> (flg_ld_sel ? shad_c : alu_c)
  - else hold
- Z: flg_z_ld -> (flg_ld_sel ? shad_z : alu_z), else hold.
- Shadow: flg_shad_ld -> shad_c <= c and shad_z <= z, using pre-update values.
  - If flg_shad_ld and any C/Z load occur in the same cycle, the shadow captures the old flags and the flags take the new values.
  - If flg_ld_sel=1 and flg_shad_ld occur in the same cycle, c/z take the old shadow and the shadow takes the old c/z (swap).
- I flag priority:
  - int_ack or i_clr -> 0
  - else i_set -> 1
  - else hold
- Interrupt entry therefore masks further interrupts automatically.
- Synchroniser: irq_in passes through a SYNC_STAGES-deep shift chain; irq_s is the last stage. irq_d is irq_s delayed one cycle.
- EDGE_MODE=1:
  - rise = irq_s & ~irq_d.
  - Pending set on rise; cleared on int_ack; set wins if both occur in the same cycle.
  - Pending latches even while i_en=0, so a masked interrupt is serviced once SEI executes.
  - Multiple edges before ack collapse into one.
- EDGE_MODE=0: int_pending <= irq_s every cycle. int_ack does not affect it.
- Latency, SYNC_STAGES=2, EDGE_MODE=1: irq_in sampled high at edge k -> int_pending high after edge k+2 -> interrupt high the same cycle if i_en=1.
- interrupt is the AND of two registers, so no combinational path exists from any input to it.
- reset asserted mid-operation: all state cleared on that edge; a pending interrupt is discarded.
- Simultaneous flg_c_set and flg_c_clr: clear wins.

Decomposition:
- Shared package: none new. Flag-source encoding FLG_SRC_ALU=0 and FLG_SRC_SHAD=1 goes into the CPU package beside the control unit's mux-select constants.
- Sub-module irq_sync (parameter SYNC_STAGES) containing the synchroniser chain and the rise-detect output.
- Flag and I registers stay in the top module.

Test Plan:
- Reset: drive everything high, assert reset one cycle -> all outputs 0 next cycle.
- Flags:
  - alu_c=1, alu_z=1, flg_c_ld=1, flg_z_ld=1 -> c=1, z=1.
  - Then flg_c_clr=1 together with flg_c_ld=1 -> c=0.
  - Then flg_c_set=1 -> c=1.
- Shadow round-trip:
  - c=1, z=0, flg_shad_ld=1 -> shad_c=1, shad_z=0.
  - ALU loads c=0, z=1.
  - flg_ld_sel=1 with flg_c_ld=1 and flg_z_ld=1 -> c=1, z=0.
- Masked interrupt (EDGE_MODE=1):
  - i_en=0, pulse irq_in high for 1 cycle -> int_pending=1 two edges later, interrupt=0.
  - i_set=1 -> interrupt=1 next cycle.
  - int_ack=1 -> int_pending=0 and i_en=0 next cycle.
- Ack collision: rise arriving in the same cycle as int_ack -> int_pending stays 1. A second irq pulse before ack -> still a single pending.
- Level mode (EDGE_MODE=0): hold irq_in=1 for 5 cycles with i_en=1 -> interrupt high from 2 edges after the rise until 2 edges after the fall; int_ack has no effect.
